// File: rtl/param_queue_pkg.sv
// param_queue_pkg: shared defaults and sizing helpers for the param_queue FIFO.
package param_queue_pkg;

   localparam int DEFAULT_WIDTH = 128;
   localparam int DEFAULT_DEPTH = 4;

   // Bits needed to hold an occupancy value in the range 0..depth.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address depth entries (depth is a power of two).
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/param_queue_mem.sv
// queue_mem: payload storage for param_queue. One synchronous write port,
// one asynchronous read port, no reset on the array.
module queue_mem
   import param_queue_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [ptr_width(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]            wdata,
   input  logic [ptr_width(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]            rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry when the controller commits an enqueue.
   // NOTE: the array has no reset; occupancy is tracked by the pointers and
   // count, so stale contents are never observed and the array maps to plain RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_queue.sv
// param_queue: parameterised synchronous FIFO with valid/ready handshakes,
// flush, occupancy count and almost-full/almost-empty flags.
// Optional feature: define PARAM_QUEUE_BYPASS_EN to let an entry offered to an
// empty queue appear on the dequeue side in the same cycle.
module param_queue
   import param_queue_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush_i,
   input  logic                        enq_valid_i,
   input  logic [WIDTH-1:0]            data_i,
   output logic                        enq_rdy_o,
   output logic                        deq_valid_o,
   output logic [WIDTH-1:0]            data_o,
   input  logic                        deq_rdy_i,
   output logic [occ_width(DEPTH)-1:0] count_o,
   output logic                        almost_full_o,
   output logic                        almost_empty_o
);

   localparam int CW = occ_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mem_rdata;
   logic             full;
   logic             empty;
   logic             head_valid;
   logic             bypass;
   logic             wr_en;
   logic             rd_en;

   queue_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (data_i),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   // Handshake decode and dequeue-side output mux.
   // NOTE: every signal gets a default at the top so no path leaves a latch.
   always_comb begin
      full        = 1'b0;
      empty       = 1'b0;
      head_valid  = 1'b0;
      bypass      = 1'b0;
      enq_rdy_o   = 1'b0;
      deq_valid_o = 1'b0;
      data_o      = '0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;

      full       = (count == FULL_LVL);
      empty      = (count == '0);
      head_valid = !empty && !reset;

      // Ready never looks at deq_rdy_i: a full queue does not pass through.
      enq_rdy_o = !full && !reset;

`ifdef PARAM_QUEUE_BYPASS_EN
      // An offer to an empty queue is presented straight to the consumer.
      bypass      = empty && enq_valid_i && !reset && !flush_i;
      deq_valid_o = bypass || head_valid;
      if (bypass) begin
         data_o = data_i;
      end else if (head_valid) begin
         data_o = mem_rdata;
      end
`else
      deq_valid_o = head_valid;
      if (head_valid) begin
         data_o = mem_rdata;
      end
`endif

      // A bypassed entry taken by the consumer is never stored.
      wr_en = enq_valid_i && enq_rdy_o && !flush_i && !(bypass && deq_rdy_i);
      rd_en = head_valid && deq_rdy_i && !flush_i;
   end

   // Pointer and occupancy state; reset outranks flush, flush outranks handshakes.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Occupancy outputs come from the count register only.
   always_comb begin
      count_o        = count;
      almost_full_o  = (count >= AF_LVL);
      almost_empty_o = (count <= AE_LVL);
   end

endmodule

// File: tb/tb_param_queue.sv
// tb_param_queue: directed vector table, hand-written bypass sequence and a
// randomized run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_param_queue;

   localparam int W = 128;
   localparam int D = 4;
`ifdef PARAM_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         flush_i;
   logic         enq_valid_i;
   logic [W-1:0] data_i;
   logic         enq_rdy_o;
   logic         deq_valid_o;
   logic [W-1:0] data_o;
   logic         deq_rdy_i;
   logic [2:0]   count_o;
   logic         almost_full_o;
   logic         almost_empty_o;

   int n_pass  = 0;
   int n_total = 0;

   param_queue dut (
      .clk            (clk),
      .reset          (reset),
      .flush_i        (flush_i),
      .enq_valid_i    (enq_valid_i),
      .data_i         (data_i),
      .enq_rdy_o      (enq_rdy_o),
      .deq_valid_o    (deq_valid_o),
      .data_o         (data_o),
      .deq_rdy_i      (deq_rdy_i),
      .count_o        (count_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      bit           rst;
      bit           fl;
      bit           ev;
      logic [W-1:0] din;
      bit           dr;
      logic [2:0]   cnt;
      bit           rdy;
      bit           dv;
      logic [W-1:0] dout;
      bit           af;
      bit           ae;
      bit           chk_occ;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge and let them settle before any sampling.
   task automatic apply(input bit rst, input bit fl, input bit ev, input logic [W-1:0] din, input bit dr);
      @(negedge clk);
      reset       = rst;
      flush_i     = fl;
      enq_valid_i = ev;
      data_i      = din;
      deq_rdy_i   = dr;
      #1;
   endtask

   function automatic vec_t mk(bit rst, bit fl, bit ev, logic [W-1:0] din, bit dr,
                               logic [2:0] cnt, bit rdy, bit dv, logic [W-1:0] dout,
                               bit af, bit ae, bit chk_occ = 1'b1);
      vec_t v;
      v.rst = rst; v.fl = fl; v.ev = ev; v.din = din; v.dr = dr;
      v.cnt = cnt; v.rdy = rdy; v.dv = dv; v.dout = dout;
      v.af = af; v.ae = ae; v.chk_occ = chk_occ;
      return v;
   endfunction

   // Reference model: a plain queue of stored payloads.
   logic [W-1:0] q[$];

   initial begin
      logic [W-1:0] big;
      logic [W-1:0] e_d;
      bit           e_dv;

      reset = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; data_i = '0; deq_rdy_i = 1'b0;
      @(posedge clk);

      //          rst fl ev din      dr  cnt rdy dv dout     af ae
      // reset held two cycles, then released
      tbl.push_back(mk(1, 0, 1, 'hA0, 1,  0, 0, 0, 0,      0, 1));
      tbl.push_back(mk(1, 0, 1, 'hA0, 1,  0, 0, 0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0,      0, 1));
      // fill to full, fifth offer ignored, then drain in order
      tbl.push_back(mk(0, 0, 1, 'hA0, 0,  0, 1, 0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 1, 'hA1, 0,  1, 1, 1, 'hA0,   0, 1));
      tbl.push_back(mk(0, 0, 1, 'hA2, 0,  2, 1, 1, 'hA0,   0, 0));
      tbl.push_back(mk(0, 0, 1, 'hA3, 0,  3, 1, 1, 'hA0,   1, 0));
      tbl.push_back(mk(0, 0, 1, 'hA4, 0,  4, 0, 1, 'hA0,   1, 0));
      tbl.push_back(mk(0, 0, 0, 0,    1,  4, 0, 1, 'hA0,   1, 0));
      tbl.push_back(mk(0, 0, 0, 0,    1,  3, 1, 1, 'hA1,   1, 0));
      tbl.push_back(mk(0, 0, 0, 0,    1,  2, 1, 1, 'hA2,   0, 0));
      tbl.push_back(mk(0, 0, 0, 0,    1,  1, 1, 1, 'hA3,   0, 1));
      tbl.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0,      0, 1));
      // prime two entries, then six concurrent enq/deq cycles across the wrap
      tbl.push_back(mk(0, 0, 1, 'hB0, 0,  0, 1, 0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 1, 'hB1, 0,  1, 1, 1, 'hB0,   0, 1));
      tbl.push_back(mk(0, 0, 1, 'hB2, 1,  2, 1, 1, 'hB0,   0, 0));
      tbl.push_back(mk(0, 0, 1, 'hB3, 1,  2, 1, 1, 'hB1,   0, 0));
      tbl.push_back(mk(0, 0, 1, 'hB4, 1,  2, 1, 1, 'hB2,   0, 0));
      tbl.push_back(mk(0, 0, 1, 'hB5, 1,  2, 1, 1, 'hB3,   0, 0));
      tbl.push_back(mk(0, 0, 1, 'hB6, 1,  2, 1, 1, 'hB4,   0, 0));
      tbl.push_back(mk(0, 0, 1, 'hB7, 1,  2, 1, 1, 'hB5,   0, 0));
      // reach three entries, then flush alongside an enqueue and a dequeue
      tbl.push_back(mk(0, 0, 1, 'hC0, 0,  2, 1, 1, 'hB6,   0, 0));
      tbl.push_back(mk(0, 1, 1, 'hC1, 1,  3, 1, 1, 'hB6,   1, 0));
      tbl.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0,      0, 1));
      // two entries, then reset mid-operation (count still registered on its first cycle)
      tbl.push_back(mk(0, 0, 1, 'hD0, 0,  0, 1, 0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 1, 'hD1, 0,  1, 1, 1, 'hD0,   0, 1));
      tbl.push_back(mk(1, 0, 1, 'hD2, 1,  2, 0, 0, 0,      0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0,    0,  0, 0, 0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0,      0, 1));

      foreach (tbl[i]) begin
         vec_t v;
         v = tbl[i];
         apply(v.rst, v.fl, v.ev, v.din, v.dr);
         e_dv = v.dv;
         e_d  = v.dout;
         if (BYP && !v.rst && !v.fl && v.cnt == 0 && v.ev) begin
            e_dv = 1'b1;
            e_d  = v.din;
         end
         check($sformatf("tbl%0d.rdy", i), W'(enq_rdy_o), W'(v.rdy));
         check($sformatf("tbl%0d.dv", i), W'(deq_valid_o), W'(e_dv));
         check($sformatf("tbl%0d.data", i), data_o, e_d);
         if (v.chk_occ) begin
            check($sformatf("tbl%0d.cnt", i), W'(count_o), W'(v.cnt));
            check($sformatf("tbl%0d.af", i), W'(almost_full_o), W'(v.af));
            check($sformatf("tbl%0d.ae", i), W'(almost_empty_o), W'(v.ae));
         end
      end

      // Empty queue, offer with consumer ready in the same cycle.
      big = 128'hAABBCCDDEEFF00112233445566778899;
      apply(0, 0, 1, big, 1);
      check("byp.cnt0", W'(count_o), W'(0));
      check("byp.dv0", W'(deq_valid_o), W'(BYP));
      check("byp.data0", data_o, BYP ? big : '0);
      apply(0, 0, 0, 0, 0);
      check("byp.cnt1", W'(count_o), BYP ? W'(0) : W'(1));
      check("byp.dv1", W'(deq_valid_o), W'(!BYP));
      check("byp.data1", data_o, BYP ? '0 : big);
      apply(0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0);
      check("byp.cnt2", W'(count_o), W'(0));
      check("byp.dv2", W'(deq_valid_o), W'(0));

      // Randomized run against the queue model, starting from a clean reset.
      apply(1, 0, 0, 0, 0);
      @(posedge clk);
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         bit           rst;
         bit           fl;
         bit           ev;
         bit           dr;
         bit           byp;
         logic [W-1:0] din;
         int           sz;
         rst = ($urandom_range(63) == 0);
         fl  = ($urandom_range(15) == 0);
         ev  = ($urandom_range(9) < 6);
         dr  = ($urandom_range(1) == 1);
         din = {$urandom, $urandom, $urandom, $urandom};
         apply(rst, fl, ev, din, dr);

         sz   = q.size();
         byp  = BYP && !rst && !fl && sz == 0 && ev;
         e_dv = byp || (!rst && sz != 0);
         e_d  = byp ? din : ((!rst && sz != 0) ? q[0] : '0);
         check("rnd.rdy", W'(enq_rdy_o), W'(!rst && sz < D));
         check("rnd.dv", W'(deq_valid_o), W'(e_dv));
         check("rnd.data", data_o, e_d);
         check("rnd.cnt", W'(count_o), W'(sz));
         check("rnd.af", W'(almost_full_o), W'(sz >= D - 1));
         check("rnd.ae", W'(almost_empty_o), W'(sz <= 1));

         @(posedge clk);
         if (rst || fl) begin
            q.delete();
         end else if (!(byp && dr)) begin
            if (sz != 0 && dr) void'(q.pop_front());
            if (ev && sz < D) q.push_back(din);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter WIDTH, default 128, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 Parameter AF_THRESH, default DEPTH-1, almost-full level, 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 1, almost-empty level, 0..DEPTH-1.
REQ-005 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush_i  input  1  synchronous discard of all stored entries.
REQ-008 enq_valid_i  input  1  producer offers data_i.
REQ-009 data_i  input  WIDTH  enqueue payload.
REQ-010 enq_rdy_o  output  1  queue accepts an entry this cycle.
REQ-011 deq_valid_o  output  1  data_o holds a valid head entry.
REQ-012 data_o  output  WIDTH  head payload.
REQ-013 deq_rdy_i  input  1  consumer takes head this cycle.
REQ-014 count_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 almost_full_o  output  1  count_o >= AF_THRESH.
REQ-016 almost_empty_o  output  1  count_o <= AE_THRESH.

Function
REQ-017 Enqueue SHALL occur on an edge where enq_valid_i && enq_rdy_o && !flush_i; dequeue where deq_valid_o && deq_rdy_i && !flush_i.
REQ-018 enq_rdy_o SHALL be !full && !reset; it SHALL NOT depend on deq_rdy_i (no pass-through when full).
REQ-019 deq_valid_o SHALL be (count_o != 0) && !reset; data_o SHALL equal entry at read pointer, else all-zero.
REQ-020 Base latency: entry enqueued at edge N SHALL appear on data_o with deq_valid_o=1 after edge N, usable by consumer in cycle N+1.
REQ-021 Read/write pointers SHALL be $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 without gap; order SHALL be strict FIFO.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count_o unchanged, advance both pointers.
REQ-023 When full, enq_valid_i SHALL be ignored and no entry overwritten; when empty, deq_rdy_i SHALL be ignored.
REQ-024 flush_i SHALL take priority over enqueue and dequeue in the same cycle: next state count=0, pointers=0; flushed data is lost.
REQ-025 count_o, almost_full_o, almost_empty_o SHALL be derived from registered state only (no input-to-output paths).

Reset
REQ-026 Reset SHALL have priority over flush_i and all handshakes.
REQ-027 While reset is high and after its release: enq_rdy_o=0 during, 1 after; deq_valid_o=0; data_o=0; count_o=0; almost_full_o=0; almost_empty_o=1.
REQ-028 Storage array SHALL NOT be reset; reset mid-operation SHALL discard all entries exactly as flush.

Configuration
REQ-029 Macro PARAM_QUEUE_BYPASS_EN SHALL enable empty-queue bypass: when count_o=0 and enq_valid_i=1 (no reset/flush), deq_valid_o=1 and data_o=data_i in the same cycle.
REQ-030 With bypass, if deq_rdy_i=1 in that cycle the entry SHALL NOT be written and count_o stays 0; otherwise it SHALL be written normally.
REQ-031 Without PARAM_QUEUE_BYPASS_EN, behaviour SHALL be REQ-019/020 exactly, with zero combinational enq-to-deq path.

Structure
REQ-032 Package param_queue_pkg SHALL hold default WIDTH/DEPTH constants and the occupancy-width helper function.
REQ-033 Storage SHALL be sub-module queue_mem (1 write port, 1 asynchronous read port, no reset); pointers/count/control live in param_queue.

Verification
REQ-034 Reset 2 cycles -> enq_rdy_o=0 during; after release enq_rdy_o=1, deq_valid_o=0, count_o=0, almost_empty_o=1.
REQ-035 DEPTH=4: enqueue 0xA0..0xA3 -> count_o=4, enq_rdy_o=0, almost_full_o=1; 5th offer 0xA4 ignored; drain yields A0,A1,A2,A3.
REQ-036 Wrap: 6 enq/deq cycles alternating with count 2 -> outputs in order, pointers wrap, count_o holds 2 on concurrent cycles.
REQ-037 count_o=3, assert flush_i with enq_valid_i=1 and deq_rdy_i=1 -> next cycle count_o=0, deq_valid_o=0, no data emitted.
REQ-038 Bypass built, empty, enq_valid_i=1 data_i=128'hAABBCCDDEEFF00112233445566778899, deq_rdy_i=1 -> same-cycle deq_valid_o=1 with that data, count_o stays 0; without macro deq_valid_o rises next cycle.
REQ-039 Reset asserted with count_o=2 -> after release count_o=0, deq_valid_o=0, data_o=0.
